pipe_skid_reg: RTL and testbench
================================

# pipe_skid_reg

Parametrised elastic pipeline-stage register for the pipelined CPU. It replaces plain enable-gated stage registers with a two-entry skid buffer. Adjacent stages are decoupled through valid/ready handshakes, and a synchronous flush squashes in-flight entries. The block sits between any two pipeline stages, for example decode→execute or execute→memory. Each stage's fields are carried as one packed WIDTH-bit payload, and throughput is one transfer per cycle.

## Interface
Parameters:
- WIDTH, default 32: payload width in bits; legal values are 1 and above.
- CLEAR_ON_FLUSH, default 1: when 1, flush also zeroes the stored payloads. When 0, only the valid state is cleared.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset; synchronous, active-high.
- flush  input  1  squash all held entries. It is synchronous and takes effect at the next clk edge.
- in_valid  input  1  upstream offers in_data.
- in_ready  output  1  block can accept an entry this cycle.
- in_data  input  WIDTH  upstream payload.
- out_valid  output  1  out_data holds a valid entry.
- out_ready  input  1  downstream consumes out_data this cycle.
- out_data  output  WIDTH  head payload.
- count  output  2  occupancy, from 0 to 2.

## Operation
- Storage consists of two registers: the main register (M), which is always the head, and the skid register (S).
- The occupancy state is EMPTY, ONE, or FULL. It is encoded directly as count = 0, 1, or 2.
- Outputs:
  - out_valid = (count != 0).
  - out_data = M.
  - in_ready = (count != 2).
- Every output is driven only from registers. There is no combinational path from in_valid or out_ready to in_ready, and none from in_valid or in_data to out_valid or out_data.
- accept = in_valid & in_ready; pop = out_valid & out_ready.
- Transitions, evaluated at each clk edge when rst=0 and flush=0:
  - EMPTY: if accept, load M ← in_data and go to ONE. Otherwise hold.
  - ONE, accept & pop: load M ← in_data and stay in ONE.
  - ONE, accept & !pop: load S ← in_data and go to FULL.
  - ONE, !accept & pop: go to EMPTY. M keeps its stale value.
  - ONE, neither: hold.
  - FULL: if pop, load M ← S and go to ONE. Otherwise hold. accept is impossible in this state because in_ready=0.
- Priority order is rst > flush > normal operation.
- flush=1:
  - Next state is EMPTY.
  - If CLEAR_ON_FLUSH=1, M and S are set to 0.
  - An accept in the flush cycle is discarded. Upstream still sees the handshake complete, so the entry is lost by design.
  - A pop in the flush cycle still counts as consumed downstream. Downstream may use out_data from that cycle.
- rst=1: count ← 0, M ← 0, S ← 0. Handshakes in the reset cycle are ignored.
- Ordering is strictly FIFO. No entry may be duplicated or dropped, except by flush.
- count is never allowed to exceed 2 and never decrements below 0.

## Timing
- Reset values: count=0, out_valid=0, in_ready=1, out_data=0.
- Latency is 1 cycle from in_data. An entry accepted at edge N is visible on out_data after edge N, whether the block was EMPTY or in ONE with a simultaneous pop.
- An entry that lands in S appears on out_data one cycle after the pop that frees M.
- Sustained throughput is 1 entry per cycle when out_ready is held at 1.
- Stall behaviour: if out_ready drops with the block in ONE, one more entry is absorbed into S. in_ready then falls after the next edge.
- Release behaviour: in_ready rises at the edge following the first pop from FULL.
- While out_valid=1 and no pop occurs, out_data and out_valid are held stable.
- in_ready may change only at clk edges.
- Flush latency: out_valid=0 and in_ready=1 from the edge after flush is asserted.
- Reset mid-operation: any occupancy returns to the reset values at the next edge.

## Test plan
- Reset: assert rst for 2 cycles with in_valid=1 and in_data=32'hDEAD_BEEF. Required: count=0, out_valid=0, out_data=0, in_ready=1 after the reset edges, and nothing is enqueued.
- Streaming: hold out_ready=1 and send 100 entries 0…99 back-to-back. Required: out_data=k exactly 1 cycle after entry k is accepted, count stays at 1, and in_ready never drops.
- Backpressure: send 1, 2, 3 with out_ready=0. Required: 1 and 2 are accepted, count=2, in_ready=0, and 3 is held upstream. Then raise out_ready. Required: out_data sequence 1, 2, 3, with no loss or duplicates.
- Simultaneous events in ONE (M=5): accept 6 with pop. Required: out_data=6, count=1. Then accept 7 without pop. Required: count=2 and S=7.
- Flush: while FULL (M=8, S=9), assert flush with in_valid=1 and in_data=10. Required next cycle: count=0, out_valid=0, in_ready=1, out_data=0 (CLEAR_ON_FLUSH=1), and 10 is discarded. With CLEAR_ON_FLUSH=0, out_data stays 8 and out_valid=0.
- Random: WIDTH=1 and WIDTH=97, 10k cycles of random in_valid, out_ready, and flush. A scoreboard checks FIFO order and drop-only-on-flush, asserts count ≤ 2, and checks that in_ready equals (count != 2) every cycle.

Source files
------------

// File: rtl/pipe_skid_reg.sv
// Elastic pipeline-stage register built as a two-entry skid buffer.
// M is always the head entry. S catches the one extra entry that arrives
// while the downstream stage stalls. All outputs come straight from
// registers, so in_ready never depends combinationally on out_ready.
module pipe_skid_reg #(
  parameter int WIDTH          = 32,
  parameter bit CLEAR_ON_FLUSH = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  // Occupancy doubles as the count output.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;

  occ_e             state_p0;
  logic [WIDTH-1:0] m_p0;
  logic [WIDTH-1:0] s_p0;
  logic             accept;
  logic             pop;

  assign in_ready  = (state_p0 != FULL);
  assign out_valid = (state_p0 != EMPTY);
  assign out_data  = m_p0;
  assign count     = state_p0;

  assign accept = in_valid & in_ready;
  assign pop    = out_valid & out_ready;

  // Occupancy FSM: reset beats flush, and flush beats any handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0 <= EMPTY;
    end else if (flush) begin
      state_p0 <= EMPTY;
    end else begin
      case (state_p0)
        EMPTY: if (accept) state_p0 <= ONE;
        ONE: begin
          if (accept && !pop)      state_p0 <= FULL;
          else if (!accept && pop) state_p0 <= EMPTY;
        end
        FULL:    if (pop) state_p0 <= ONE;
        default: state_p0 <= EMPTY;
      endcase
    end
  end

  // Payload storage. In FULL, a pop promotes S into M. Otherwise an
  // accepted entry goes to M when M is free or is being popped, and to S
  // when M is still occupied.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_p0 <= '0;
      s_p0 <= '0;
    end else if (flush) begin
      if (CLEAR_ON_FLUSH) begin
        m_p0 <= '0;
        s_p0 <= '0;
      end
    end else if (state_p0 == FULL) begin
      if (pop) m_p0 <= s_p0;
    end else if (accept) begin
      if (state_p0 == EMPTY || pop) m_p0 <= in_data;
      else                          s_p0 <= in_data;
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg. Three instances share one set of handshake
// inputs: a 97-bit clearing instance, a 1-bit instance, and a 32-bit
// instance that keeps its payload on flush. A queue-based FIFO of depth 2
// serves as the reference model.
module tb_pipe_skid_reg;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [96:0] in_data = '0;

  logic        a_in_ready, a_out_valid;
  logic [96:0] a_out_data;
  logic [1:0]  a_count;
  logic        b_in_ready, b_out_valid;
  logic [0:0]  b_out_data;
  logic [1:0]  b_count;
  logic        c_in_ready, c_out_valid;
  logic [31:0] c_out_data;
  logic [1:0]  c_count;

  int ntests = 0;
  int nfail  = 0;

  logic [96:0] exp_q[$];
  int          pre_size = 0;
  bit          known = 1'b0;

  always #5 clk = ~clk;

  pipe_skid_reg #(.WIDTH(97), .CLEAR_ON_FLUSH(1'b1)) u_a (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
    .count(a_count)
  );

  pipe_skid_reg #(.WIDTH(1), .CLEAR_ON_FLUSH(1'b1)) u_b (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data[0:0]),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
    .count(b_count)
  );

  pipe_skid_reg #(.WIDTH(32), .CLEAR_ON_FLUSH(1'b0)) u_c (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(c_in_ready), .in_data(in_data[31:0]),
    .out_valid(c_out_valid), .out_ready(out_ready), .out_data(c_out_data),
    .count(c_count)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: just before each rising edge, compare every instance with the
  // model, then retire whatever that edge consumes or squashes.
  always begin
    @(negedge clk);
    #1;
    pre_size = exp_q.size();
    if (known) begin
      chk("a_count", {126'd0, a_count}, pre_size);
      chk("b_count", {126'd0, b_count}, pre_size);
      chk("c_count", {126'd0, c_count}, pre_size);
      chk("a_out_valid", a_out_valid, pre_size != 0);
      chk("b_out_valid", b_out_valid, pre_size != 0);
      chk("c_out_valid", c_out_valid, pre_size != 0);
      chk("a_in_ready", a_in_ready, pre_size != 2);
      chk("b_in_ready", b_in_ready, pre_size != 2);
      chk("c_in_ready", c_in_ready, pre_size != 2);
      if (pre_size != 0) begin
        chk("a_out_data", a_out_data, exp_q[0]);
        chk("b_out_data", b_out_data, exp_q[0][0]);
        chk("c_out_data", c_out_data, exp_q[0][31:0]);
      end
    end
    if (rst) begin
      exp_q.delete();
      known = 1'b1;
    end else if (known) begin
      if (flush) exp_q.delete();
      else if (pre_size != 0 && out_ready) void'(exp_q.pop_front());
    end
  end

  // Drive one cycle of stimulus. The model records an accepted entry
  // after the monitor has sampled this cycle.
  task automatic step(input bit iv, input logic [96:0] d, input bit ordy,
                      input bit fl, input bit r);
    @(negedge clk);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    rst       = r;
    #2;
    if (known && !r && !fl && iv && pre_size < 2) exp_q.push_back(d);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with a live offer on the input.
    step(1'b1, 97'hDEAD_BEEF, 1'b0, 1'b0, 1'b1);
    step(1'b1, 97'hDEAD_BEEF, 1'b0, 1'b0, 1'b1);
    after_edge();
    chk("rst_count", {126'd0, a_count}, 0);
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_in_ready", a_in_ready, 1);
    chk("rst_out_data", a_out_data, 0);
    chk("rst_c_out_data", c_out_data, 0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);

    // Back-to-back streaming with downstream always ready.
    for (int k = 0; k < 100; k++) begin
      step(1'b1, 97'(k), 1'b1, 1'b0, 1'b0);
      chk("stream_in_ready", a_in_ready, 1);
      after_edge();
      chk("stream_out_data", a_out_data, 97'(k));
      chk("stream_count", {126'd0, a_count}, 1);
    end
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Backpressure: the third entry must wait upstream.
    step(1'b1, 97'd1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 97'd2, 1'b0, 1'b0, 1'b0);
    step(1'b1, 97'd3, 1'b0, 1'b0, 1'b0);
    after_edge();
    chk("bp_count", {126'd0, a_count}, 2);
    chk("bp_in_ready", a_in_ready, 0);
    chk("bp_head", a_out_data, 97'd1);
    step(1'b1, 97'd3, 1'b1, 1'b0, 1'b0);
    after_edge();
    chk("bp_release_in_ready", a_in_ready, 1);
    chk("bp_second", a_out_data, 97'd2);
    step(1'b1, 97'd3, 1'b1, 1'b0, 1'b0);
    after_edge();
    chk("bp_third", a_out_data, 97'd3);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Accept with pop in ONE, then accept without pop.
    step(1'b1, 97'd5, 1'b0, 1'b0, 1'b0);
    step(1'b1, 97'd6, 1'b1, 1'b0, 1'b0);
    after_edge();
    chk("sim_out_data", a_out_data, 97'd6);
    chk("sim_count", {126'd0, a_count}, 1);
    step(1'b1, 97'd7, 1'b0, 1'b0, 1'b0);
    after_edge();
    chk("sim_full_count", {126'd0, a_count}, 2);
    chk("sim_skid", u_a.s_p0, 97'd7);
    chk("sim_hold_head", a_out_data, 97'd6);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Flush while FULL with a concurrent offer that must be discarded.
    step(1'b1, 97'd8, 1'b0, 1'b0, 1'b0);
    step(1'b1, 97'd9, 1'b0, 1'b0, 1'b0);
    step(1'b1, 97'd10, 1'b0, 1'b1, 1'b0);
    after_edge();
    chk("fl_count", {126'd0, a_count}, 0);
    chk("fl_out_valid", a_out_valid, 0);
    chk("fl_in_ready", a_in_ready, 1);
    chk("fl_out_data_clear", a_out_data, 0);
    chk("fl_c_out_data_keep", c_out_data, 8);
    chk("fl_c_out_valid", c_out_valid, 0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 10000; i++) begin
      step(1'(($urandom & 3) != 0),
           {$urandom, $urandom, $urandom, $urandom},
           1'(($urandom & 3) != 0),
           1'($urandom_range(0, 31) == 0),
           1'($urandom_range(0, 499) == 0));
    end
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
